// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state encoding and bit-reverse helper for the 32-point FFT sequencer
package fft_pkg;

  localparam int N_POINTS = 32;
  localparam int LOG2N    = 5;
  localparam int ADDR_W   = 5;
  localparam int STAGE_W  = 3;          // wide enough to hold stage numbers 0..LOG2N-1
  localparam int BFLY_W   = LOG2N - 1;  // butterfly index and twiddle exponent width

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Mirror the address bits so natural-order input lands in bit-reversed memory order
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = v[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// rtl/fft_bfly_addr_gen.sv - maps (stage, butterfly index) to operand addresses and twiddle exponent
module fft_bfly_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [BFLY_W-1:0]  bfly_i,
  output logic [ADDR_W-1:0]  addr_a_o,
  output logic [ADDR_W-1:0]  addr_b_o,
  output logic [BFLY_W-1:0]  tw_o
);

  logic [ADDR_W-1:0] j_ext;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] a;

  // Insert a zero at bit position s of j to get the top operand; the bottom one sits 2^s above it
  always_comb begin
    j_ext    = ADDR_W'(bfly_i);
    mask     = (ADDR_W'(1) << stage_i) - ADDR_W'(1);
    a        = ((j_ext >> stage_i) << (stage_i + STAGE_W'(1))) | (j_ext & mask);
    addr_a_o = a;
    addr_b_o = a + (ADDR_W'(1) << stage_i);
    tw_o     = BFLY_W'((j_ext & mask) << (STAGE_W'(BFLY_W) - stage_i));
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - LOAD/RUN/DRAIN frame scheduler for the 32-point radix-2 DIT FFT datapath
module fft_frame_sequencer
  import fft_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LOG2N-1:0]  E,
  output logic [BFLY_W-1:0] S,
  output logic [ADDR_W-1:0] bf_addr_a,
  output logic [ADDR_W-1:0] bf_addr_b,
  output logic [BFLY_W-1:0] tw_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0]  CNT_LAST   = ADDR_W'(N_POINTS - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [BFLY_W-1:0]  BFLY_LAST  = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BFLY_W-1:0]  bfly_q, bfly_d;
  logic [LOG2N-1:0]   e_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [ADDR_W-1:0]  bf_a_q, bf_b_q;
  logic [BFLY_W-1:0]  tw_q;
  logic               out_last_q, busy_q, done_q;
  logic [ADDR_W-1:0]  gen_a, gen_b;
  logic [BFLY_W-1:0]  gen_tw;
  logic               in_hs, out_hs;

  // Addresses are generated from the next (stage, j) so the registered copies line up with E and S
  fft_bfly_addr_gen u_addr_gen (
    .stage_i  (stage_d),
    .bfly_i   (bfly_d),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_o     (gen_tw)
  );

  // Handshake qualifiers drop together with EN so a frozen block never accepts or offers data
  assign in_ready  = (state_q == LOAD) & EN;
  assign out_valid = (state_q == DRAIN) & EN;
  assign wr_en     = in_valid & in_ready;
  assign in_hs     = wr_en;
  assign out_hs    = out_valid & out_ready;

  assign wr_addr   = wr_addr_q;
  assign E         = EN ? e_q : '0;
  assign S         = bfly_q;
  assign bf_addr_a = bf_a_q;
  assign bf_addr_b = bf_b_q;
  assign tw_idx    = tw_q;
  assign rd_addr   = cnt_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state for the frame FSM, the shared sample counter and the {stage, j} butterfly counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            stage_d = '0;
            bfly_d  = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      RUN: begin
        if (EN) begin
          if (bfly_q == BFLY_LAST) begin
            bfly_d = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = DRAIN;
              stage_d = '0;
            end else begin
              stage_d = stage_q + STAGE_W'(1);
            end
          end else begin
            bfly_d = bfly_q + BFLY_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        stage_d = '0;
        bfly_d  = '0;
      end
    endcase
  end

  // State, counters and every registered output; with EN low the next-state equals the current one
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      stage_q    <= '0;
      bfly_q     <= '0;
      e_q        <= '0;
      wr_addr_q  <= '0;
      bf_a_q     <= '0;
      bf_b_q     <= ADDR_W'(1);
      tw_q       <= '0;
      out_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      bfly_q     <= bfly_d;
      e_q        <= (state_d == RUN) ? (LOG2N'(1) << stage_d) : '0;
      wr_addr_q  <= bitrev(cnt_d);
      bf_a_q     <= gen_a;
      bf_b_q     <= gen_b;
      tw_q       <= gen_tw;
      out_last_q <= (state_d == DRAIN) && (cnt_d == CNT_LAST);
      busy_q     <= (state_d != LOAD) || (cnt_d != '0);
      done_q     <= out_hs && (cnt_q == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

  logic       CLK = 1'b0;
  logic       RST, EN, in_valid, out_ready;
  logic       in_ready, wr_en, out_valid, out_last, busy, done;
  logic [4:0] wr_addr, E, bf_addr_a, bf_addr_b, rd_addr;
  logic [3:0] S, tw_idx;

  int checks = 0;
  int errors = 0;

  fft_frame_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .E         (E),
    .S         (S),
    .bf_addr_a (bf_addr_a),
    .bf_addr_b (bf_addr_b),
    .tw_idx    (tw_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_addr   (rd_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] br(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (E !== 5'd0) begin errors++; $display("FAIL reset_E got %b want 00000", E); end
    checks++; if (S !== 4'd0) begin errors++; $display("FAIL reset_S got %0d want 0", S); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
  endtask

  task automatic test_load();
    logic [4:0] exp;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK); in_valid = 1'b1; #1;
      exp = br(5'(i));
      checks++;
      if (wr_addr !== exp || wr_en !== 1'b1) begin
        errors++; $display("FAIL load_wr_addr[%0d] got %0d wr_en %0b want %0d wr_en 1", i, wr_addr, wr_en, exp);
      end
    end
    @(negedge CLK); #1;
    checks++;
    if (E !== 5'b00001 || S !== 4'd0 || in_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL load_to_run got E %b S %0d in_ready %0b wr_en %0b busy %0b want E 00001 S 0 in_ready 0 wr_en 0 busy 1", E, S, in_ready, wr_en, busy);
    end
  endtask

  task automatic test_run();
    int rc;
    int bad_wr;
    rc = 0; bad_wr = 0; out_ready = 1'b0;
    while (E !== 5'd0 && rc < 200) begin
      if (wr_en !== 1'b0) bad_wr++;
      if (rc == 1) begin
        checks++;
        if (E !== 5'b00001 || S !== 4'd1 || bf_addr_a !== 5'd2 || bf_addr_b !== 5'd3 || tw_idx !== 4'd0) begin
          errors++; $display("FAIL run_s0_j1 got E %b S %0d a %0d b %0d tw %0d want E 00001 S 1 a 2 b 3 tw 0", E, S, bf_addr_a, bf_addr_b, tw_idx);
        end
      end
      if (rc == 37) begin
        checks++;
        if (E !== 5'b00100 || S !== 4'd5 || bf_addr_a !== 5'd9 || bf_addr_b !== 5'd13 || tw_idx !== 4'd4) begin
          errors++; $display("FAIL run_s2_j5 got E %b S %0d a %0d b %0d tw %0d want E 00100 S 5 a 9 b 13 tw 4", E, S, bf_addr_a, bf_addr_b, tw_idx);
        end
      end
      if (rc == 79) begin
        checks++;
        if (E !== 5'b10000 || S !== 4'd15 || bf_addr_a !== 5'd15 || bf_addr_b !== 5'd31 || tw_idx !== 4'd15) begin
          errors++; $display("FAIL run_s4_j15 got E %b S %0d a %0d b %0d tw %0d want E 10000 S 15 a 15 b 31 tw 15", E, S, bf_addr_a, bf_addr_b, tw_idx);
        end
      end
      rc++;
      @(negedge CLK); #1;
    end
    checks++; if (rc !== 80) begin errors++; $display("FAIL run_length got %0d want 80", rc); end
    checks++;
    if (out_valid !== 1'b1 || rd_addr !== 5'd0 || out_last !== 1'b0) begin
      errors++; $display("FAIL drain_entry got out_valid %0b rd_addr %0d out_last %0b want 1 0 0", out_valid, rd_addr, out_last);
    end
    checks++; if (bad_wr !== 0) begin errors++; $display("FAIL run_wr_en got %0d pulses want 0", bad_wr); end
  endtask

  task automatic test_drain();
    int bad_wr;
    int pulses;
    logic exp_last;
    bad_wr = 0; pulses = 0;
    for (int k = 0; k < 32; k++) begin
      exp_last = (k == 31);
      @(negedge CLK); out_ready = 1'b0; #1;
      if (wr_en !== 1'b0) bad_wr++;
      if (done !== 1'b0) pulses++;
      checks++;
      if (out_valid !== 1'b1 || rd_addr !== 5'(k) || out_last !== exp_last) begin
        errors++; $display("FAIL drain_beat[%0d] got out_valid %0b rd_addr %0d out_last %0b want 1 %0d %0b", k, out_valid, rd_addr, out_last, k, exp_last);
      end
      @(negedge CLK); out_ready = 1'b1; #1;
      if (wr_en !== 1'b0) bad_wr++;
      if (done !== 1'b0) pulses++;
      checks++;
      if (rd_addr !== 5'(k) || out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_hold[%0d] got rd_addr %0d out_valid %0b want %0d 1", k, rd_addr, out_valid, k);
      end
    end
    @(negedge CLK); out_ready = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL drain_done got done %0b in_ready %0b out_valid %0b busy %0b want 1 1 0 0", done, in_ready, out_valid, busy);
    end
    @(negedge CLK); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %0b want 0", done); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL drain_early_done got %0d want 0", pulses); end
    checks++; if (bad_wr !== 0) begin errors++; $display("FAIL drain_wr_en got %0d pulses want 0", bad_wr); end
  endtask

  task automatic test_en_freeze();
    int rc;
    int hs;
    logic found;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK); in_valid = 1'b1;
    end
    @(negedge CLK); in_valid = 1'b0;
    repeat (39) @(negedge CLK);
    #1;
    checks++;
    if (E !== 5'b00100 || S !== 4'd7) begin
      errors++; $display("FAIL freeze_pre got E %b S %0d want 00100 7", E, S);
    end
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (E !== 5'd0 || S !== 4'd7 || bf_addr_a !== 5'd11 || bf_addr_b !== 5'd15 || tw_idx !== 4'd12 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL freeze_hold[%0d] got E %b S %0d a %0d b %0d tw %0d in_ready %0b out_valid %0b want 00000 7 11 15 12 0 0", i, E, S, bf_addr_a, bf_addr_b, tw_idx, in_ready, out_valid);
      end
      @(negedge CLK);
    end
    EN = 1'b1; #1;
    checks++;
    if (E !== 5'b00100 || S !== 4'd7) begin
      errors++; $display("FAIL freeze_resume got E %b S %0d want 00100 7", E, S);
    end
    rc = 39;
    while (E !== 5'd0 && rc < 200) begin
      if (rc == 40) begin
        checks++;
        if (E !== 5'b00100 || S !== 4'd8) begin
          errors++; $display("FAIL freeze_next got E %b S %0d want 00100 8", E, S);
        end
      end
      rc++;
      @(negedge CLK); #1;
    end
    checks++; if (rc !== 80) begin errors++; $display("FAIL freeze_run_length got %0d want 80", rc); end
    out_ready = 1'b1; hs = 0; found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done === 1'b1) begin found = 1'b1; break; end
      if (out_valid === 1'b1 && out_ready === 1'b1) hs++;
      @(negedge CLK); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (found !== 1'b1 || hs !== 32) begin
      errors++; $display("FAIL fast_drain got done_seen %0b beats %0d want 1 32", found, hs);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK); in_valid = 1'b1;
    end
    @(negedge CLK); #1;
    checks++;
    if (wr_addr !== 5'd17 || busy !== 1'b1) begin
      errors++; $display("FAIL midload_state got wr_addr %0d busy %0b want 17 1", wr_addr, busy);
    end
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (wr_addr !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1 || E !== 5'd0) begin
      errors++; $display("FAIL midload_reset got wr_addr %0d busy %0b in_ready %0b E %b want 0 0 1 00000", wr_addr, busy, in_ready, E);
    end
    test_load();
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_drain();
    test_en_freeze();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
